// File: rtl/mouse_marker_drag.sv
// ============================================================================
// Module      : mouse_marker_drag
// Description : Mouse drag handler for NUM_MARKERS horizontal level markers
//               sharing one handle column. A left press grabs the hovered
//               marker. While the button is held, the marker follows the
//               clamped cursor Y. A left release commits the new level. A
//               middle click cancels the drag and restores the pre-drag
//               level. A right click on a hovered marker resets it to its
//               default level.
// Ports       : CLK_50MHZ, MASTER_RST (async, active-high)
//               XCOORD/YCOORD   cursor position
//               L/R/M_BUTTON    mouse button levels
//               LEVELS          packed marker levels, marker 0 in LSBs
//               HOVER           one-hot marker under cursor (comb, 0 in drag)
//               DRAGGING/ACTIVE drag status and one-hot dragged marker
//               RELEASE_PULSE   one cycle, drag committed
//               CANCEL_PULSE    one cycle, drag cancelled
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_marker_drag #(
  parameter int NUM_MARKERS = 4,
  parameter int COORD_W     = 12,
  parameter int LEVEL_W     = 9,
  parameter int HANDLE_XMIN = 556,
  parameter int HANDLE_XMAX = 558,
  parameter int HIT_TOL     = 1,
  parameter int LEVEL_MIN   = 8,
  parameter int LEVEL_MAX   = 471,
  parameter logic [NUM_MARKERS*LEVEL_W-1:0] DEFAULT_LEVELS =
    {9'd50, 9'd100, 9'd150, 9'd200}
) (
  input  logic                           CLK_50MHZ,
  input  logic                           MASTER_RST,
  input  logic [COORD_W-1:0]             XCOORD,
  input  logic [COORD_W-1:0]             YCOORD,
  input  logic                           L_BUTTON,
  input  logic                           R_BUTTON,
  input  logic                           M_BUTTON,
  output logic [NUM_MARKERS*LEVEL_W-1:0] LEVELS,
  output logic [NUM_MARKERS-1:0]         HOVER,
  output logic                           DRAGGING,
  output logic [NUM_MARKERS-1:0]         ACTIVE,
  output logic                           RELEASE_PULSE,
  output logic                           CANCEL_PULSE
);

  localparam int CW1   = COORD_W + 1;
  localparam int IDX_W = (NUM_MARKERS > 1) ? $clog2(NUM_MARKERS) : 1;

  // Hit-test constants live at COORD_W+1 bits so level+HIT_TOL cannot wrap.
  localparam logic [CW1-1:0]     c_xmin  = CW1'(HANDLE_XMIN);
  localparam logic [CW1-1:0]     c_xmax  = CW1'(HANDLE_XMAX);
  localparam logic [CW1-1:0]     c_tol   = CW1'(HIT_TOL);
  localparam logic [COORD_W-1:0] c_ymin  = COORD_W'(LEVEL_MIN);
  localparam logic [COORD_W-1:0] c_ymax  = COORD_W'(LEVEL_MAX);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DRAG = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [LEVEL_W-1:0]     r_level     [NUM_MARKERS];
  logic [LEVEL_W-1:0]     w_level_nxt [NUM_MARKERS];
  logic [LEVEL_W-1:0]     r_saved, w_saved_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [NUM_MARKERS-1:0] r_active, w_active_nxt;
  logic                   r_rel, w_rel_nxt;
  logic                   r_can, w_can_nxt;
  logic                   r_l_buf, r_r_buf, r_m_buf;

  logic                   w_l_rise, w_l_fall, w_r_rise, w_m_rise;
  logic [CW1-1:0]         w_x, w_y;
  logic                   w_x_in;
  logic [NUM_MARKERS-1:0] w_hit;
  logic [NUM_MARKERS-1:0] w_hover_raw;
  logic [IDX_W-1:0]       w_hover_idx;
  logic                   w_any;
  logic [LEVEL_W-1:0]     w_clamp;

  assign w_l_rise =  L_BUTTON & ~r_l_buf;
  assign w_l_fall = ~L_BUTTON &  r_l_buf;
  assign w_r_rise =  R_BUTTON & ~r_r_buf;
  assign w_m_rise =  M_BUTTON & ~r_m_buf;

  assign w_x    = {1'b0, XCOORD};
  assign w_y    = {1'b0, YCOORD};
  assign w_x_in = (w_x >= c_xmin) && (w_x <= c_xmax);

  // Per-marker grab window; the lower bound saturates at 0.
  for (genvar g = 0; g < NUM_MARKERS; g++) begin : g_hit
    logic [CW1-1:0] w_lvl, w_lo, w_hi;
    assign w_lvl    = CW1'(r_level[g]);
    assign w_lo     = (w_lvl >= c_tol) ? (w_lvl - c_tol) : '0;
    assign w_hi     = w_lvl + c_tol;
    assign w_hit[g] = (w_lo <= w_y) && (w_y <= w_hi) && w_x_in;
  end

  // Scanning from the top down lets the lowest index win on overlap.
  always_comb begin
    w_hover_raw = '0;
    w_hover_idx = '0;
    for (int i = NUM_MARKERS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hover_raw    = '0;
        w_hover_raw[i] = 1'b1;
        w_hover_idx    = IDX_W'(i);
      end
    end
  end
  assign w_any = |w_hit;

  // Clamp at full coordinate width so large Y never truncates into range.
  always_comb begin
    if (YCOORD < c_ymin)      w_clamp = LEVEL_W'(LEVEL_MIN);
    else if (YCOORD > c_ymax) w_clamp = LEVEL_W'(LEVEL_MAX);
    else                      w_clamp = YCOORD[LEVEL_W-1:0];
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_saved_nxt  = r_saved;
    w_idx_nxt    = r_idx;
    w_active_nxt = r_active;
    w_rel_nxt    = 1'b0;
    w_can_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_l_rise && w_any) begin
          w_state_nxt  = ST_DRAG;
          w_idx_nxt    = w_hover_idx;
          w_active_nxt = w_hover_raw;
          for (int i = 0; i < NUM_MARKERS; i++)
            if (IDX_W'(i) == w_hover_idx) w_saved_nxt = r_level[i];
        end else if (w_r_rise && w_any) begin
          for (int i = 0; i < NUM_MARKERS; i++)
            if (IDX_W'(i) == w_hover_idx)
              w_level_nxt[i] = DEFAULT_LEVELS[i*LEVEL_W +: LEVEL_W];
        end
      end
      ST_DRAG: begin
        if (w_m_rise) begin
          for (int i = 0; i < NUM_MARKERS; i++)
            if (IDX_W'(i) == r_idx) w_level_nxt[i] = r_saved;
          w_state_nxt  = ST_IDLE;
          w_active_nxt = '0;
          w_can_nxt    = 1'b1;
        end else if (w_l_fall) begin
          w_state_nxt  = ST_IDLE;
          w_active_nxt = '0;
          w_rel_nxt    = 1'b1;
        end else begin
          for (int i = 0; i < NUM_MARKERS; i++)
            if (IDX_W'(i) == r_idx) w_level_nxt[i] = w_clamp;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_active_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge MASTER_RST) begin
    if (MASTER_RST) begin
      r_state  <= ST_IDLE;
      for (int i = 0; i < NUM_MARKERS; i++)
        r_level[i] <= DEFAULT_LEVELS[i*LEVEL_W +: LEVEL_W];
      r_saved  <= '0;
      r_idx    <= '0;
      r_active <= '0;
      r_rel    <= 1'b0;
      r_can    <= 1'b0;
      r_l_buf  <= 1'b0;
      r_r_buf  <= 1'b0;
      r_m_buf  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      for (int i = 0; i < NUM_MARKERS; i++)
        r_level[i] <= w_level_nxt[i];
      r_saved  <= w_saved_nxt;
      r_idx    <= w_idx_nxt;
      r_active <= w_active_nxt;
      r_rel    <= w_rel_nxt;
      r_can    <= w_can_nxt;
      r_l_buf  <= L_BUTTON;
      r_r_buf  <= R_BUTTON;
      r_m_buf  <= M_BUTTON;
    end
  end

  for (genvar g = 0; g < NUM_MARKERS; g++) begin : g_pack
    assign LEVELS[g*LEVEL_W +: LEVEL_W] = r_level[g];
  end

  assign HOVER         = (r_state == ST_DRAG) ? '0 : w_hover_raw;
  assign DRAGGING      = (r_state == ST_DRAG);
  assign ACTIVE        = r_active;
  assign RELEASE_PULSE = r_rel;
  assign CANCEL_PULSE  = r_can;

endmodule

`default_nettype wire

// File: tb/tb_mouse_marker_drag.sv
// ============================================================================
// Module      : tb_mouse_marker_drag
// Description : Scoreboard bench for mouse_marker_drag. The driver computes
//               the expected outputs from a behavioural model and queues
//               them. The monitor compares them one clock later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mouse_marker_drag;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xc = '0, yc = '0;
  logic        lb = 1'b0, rb = 1'b0, mb = 1'b0;
  logic [35:0] levels;
  logic [3:0]  hover, active;
  logic        dragging, rel_p, can_p;

  always #10 clk = ~clk;

  mouse_marker_drag dut (
    .CLK_50MHZ    (clk),
    .MASTER_RST   (rst),
    .XCOORD       (xc),
    .YCOORD       (yc),
    .L_BUTTON     (lb),
    .R_BUTTON     (rb),
    .M_BUTTON     (mb),
    .LEVELS       (levels),
    .HOVER        (hover),
    .DRAGGING     (dragging),
    .ACTIVE       (active),
    .RELEASE_PULSE(rel_p),
    .CANCEL_PULSE (can_p)
  );

  typedef struct {
    logic [35:0] levels;
    logic [3:0]  hover;
    logic        drag;
    logic [3:0]  act;
    logic        rel;
    logic        can;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Behavioural reference model state.
  int   def_lvl[4] = '{200, 150, 100, 50};
  int   m_lvl[4];
  bit   m_drag;
  int   m_act, m_saved;
  bit   m_pl, m_pr, m_pm;

  // Index of the marker the cursor would grab, or -1.
  function automatic int hov(int x, int y);
    for (int i = 0; i < 4; i++) begin
      int lo, hi;
      lo = (m_lvl[i] >= 1) ? m_lvl[i] - 1 : 0;
      hi = m_lvl[i] + 1;
      if (x >= 556 && x <= 558 && y >= lo && y <= hi) return i;
    end
    return -1;
  endfunction

  function automatic int clampy(int y);
    if (y < 8)   return 8;
    if (y > 471) return 471;
    return y;
  endfunction

  task automatic step(input int x, input int y, input bit l, input bit r,
                      input bit m, input bit rs);
    exp_t e;
    int   h;
    bit   rel, can;
    @(negedge clk);
    xc  = 12'(x);
    yc  = 12'(y);
    lb  = l;
    rb  = r;
    mb  = m;
    rst = rs;
    rel = 0;
    can = 0;
    if (rs) begin
      for (int i = 0; i < 4; i++) m_lvl[i] = def_lvl[i];
      m_drag = 0; m_act = 0; m_saved = 0;
      m_pl = 0; m_pr = 0; m_pm = 0;
    end else begin
      h = hov(x, y);
      if (!m_drag) begin
        if (l && !m_pl && h >= 0) begin
          m_drag = 1; m_act = h; m_saved = m_lvl[h];
        end else if (r && !m_pr && h >= 0) begin
          m_lvl[h] = def_lvl[h];
        end
      end else begin
        if (m && !m_pm) begin
          m_lvl[m_act] = m_saved; m_drag = 0; can = 1;
        end else if (!l && m_pl) begin
          m_drag = 0; rel = 1;
        end else begin
          m_lvl[m_act] = clampy(y);
        end
      end
      m_pl = l; m_pr = r; m_pm = m;
    end
    for (int i = 0; i < 4; i++) e.levels[i*9 +: 9] = 9'(m_lvl[i]);
    h       = hov(x, y);
    e.hover = (m_drag || h < 0) ? 4'b0 : 4'(1 << h);
    e.drag  = m_drag;
    e.act   = m_drag ? 4'(1 << m_act) : 4'b0;
    e.rel   = rel;
    e.can   = can;
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [35:0] a, input logic [35:0] x);
    n_cmp++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, x);
    end
  endtask

  // Monitor: outputs are presented every clock; compare #1 after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("LEVELS",   levels,          e.levels);
        cmp("HOVER",    36'(hover),      36'(e.hover));
        cmp("DRAGGING", 36'(dragging),   36'(e.drag));
        cmp("ACTIVE",   36'(active),     36'(e.act));
        cmp("RELEASE",  36'(rel_p),      36'(e.rel));
        cmp("CANCEL",   36'(can_p),      36'(e.can));
      end
    end
  end

  initial begin
    int x, y, k;
    bit l, r, m;
    // Reset and defaults
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Grab marker0, drag to 300, release
    step(557, 201, 0, 0, 0, 0);
    step(557, 201, 1, 0, 0, 0);
    step(557, 300, 1, 0, 0, 0);
    step(557, 300, 0, 0, 0, 0);
    step(557, 300, 0, 0, 0, 0);
    // Miss just right of the handle column
    step(559, 200, 0, 0, 0, 0);
    step(559, 150, 1, 0, 0, 0);
    step(559, 150, 0, 0, 0, 0);
    // Left edge of column, lower tolerance of marker at 150
    step(556, 149, 0, 0, 0, 0);
    // L held before entering handle never grabs
    step(0, 0, 1, 0, 0, 0);
    step(557, 150, 1, 0, 0, 0);
    step(557, 150, 1, 0, 0, 0);
    step(557, 150, 0, 0, 0, 0);
    // Clamp marker1 high and low
    step(557, 150, 1, 0, 0, 0);
    step(557, 4095, 1, 0, 0, 0);
    step(557, 3, 1, 0, 0, 0);
    step(557, 3, 0, 0, 0, 0);
    // Cancel marker2 drag with M rise and L fall together
    step(557, 100, 0, 0, 0, 0);
    step(557, 100, 1, 0, 0, 0);
    step(557, 250, 1, 0, 0, 0);
    step(557, 250, 0, 0, 1, 0);
    step(557, 250, 0, 0, 0, 0);
    // Move marker1 (now 8) and marker0 (300) both to 150
    step(557, 8, 1, 0, 0, 0);
    step(557, 150, 1, 0, 0, 0);
    step(557, 150, 0, 0, 0, 0);
    step(557, 300, 1, 0, 0, 0);
    step(557, 150, 1, 0, 0, 0);
    step(557, 150, 0, 0, 0, 0);
    // Overlap: lowest index hovers; right click resets marker0 only
    step(557, 150, 0, 0, 0, 0);
    step(557, 150, 0, 1, 0, 0);
    step(557, 150, 0, 0, 0, 0);
    // L and R rise together: left wins
    step(557, 150, 1, 1, 0, 0);
    step(557, 150, 0, 0, 0, 0);
    // Reset mid-drag on marker3
    step(557, 50, 1, 0, 0, 0);
    step(557, 60, 1, 0, 0, 0);
    step(557, 60, 1, 0, 0, 1);
    step(557, 60, 0, 0, 0, 0);
    step(557, 60, 0, 0, 0, 0);
    // Randomized traffic
    l = 0; r = 0; m = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)  l = ~l;
      if ($urandom_range(0, 15) == 0) r = ~r;
      if ($urandom_range(0, 31) == 0) m = ~m;
      if ($urandom_range(0, 9) < 7) x = int'($urandom_range(554, 560));
      else                          x = int'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 0) begin
        k = int'($urandom_range(0, 3));
        y = m_lvl[k] + int'($urandom_range(0, 6)) - 3;
        if (y < 0) y = 0;
      end else begin
        y = int'($urandom_range(0, 4095));
      end
      step(x, y, l, r, m, ($urandom_range(0, 499) == 0));
    end
    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
